// File: rtl/partition_err_sweep_if.sv
// Purpose : bundles the sweep request, the partition stimulus/response pair and
//           the error-statistics results of partition_err_sweep into one port.
// Ports   : start, po_exact, po_approx flow host -> sweeper;
//           pi, busy, done, err_count, bit_err_sum, max_abs_err flow sweeper -> host.
interface partition_err_sweep_if #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 4
);
  logic              start;
  logic [IN_W-1:0]   pi;
  logic [OUT_W-1:0]  po_exact;
  logic [OUT_W-1:0]  po_approx;
  logic              busy;
  logic              done;
  logic [IN_W:0]     err_count;
  logic [IN_W+3:0]   bit_err_sum;
  logic [OUT_W-1:0]  max_abs_err;

  // Host side: requests sweeps and evaluates the partitions on pi.
  modport master (
    output start, po_exact, po_approx,
    input  pi, busy, done, err_count, bit_err_sum, max_abs_err
  );

  // Sweeper side.
  modport slave (
    input  start, po_exact, po_approx,
    output pi, busy, done, err_count, bit_err_sum, max_abs_err
  );
endinterface

// File: rtl/partition_err_sweep.sv
// Purpose : exhaustively drives pi = 0..2^IN_W-1 into an exact and an approximate
//           partition and accumulates mismatch count, Hamming sum and max |error|.
// Latency : done pulses 2^IN_W+1 cycles after the edge that accepts start.
// Backpr. : none; start is only honoured in IDLE and ignored otherwise.
// Ports   : clk, rst (async, active-high); bus = partition_err_sweep_if.slave.
module partition_err_sweep #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  partition_err_sweep_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SWEEP = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [IN_W-1:0]   CNT_LAST = {IN_W{1'b1}};
  localparam logic [IN_W-1:0]   CNT_ONE  = 1;
  localparam logic [OUT_W-1:0]  OUT_ONE  = 1;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_busy;
  logic              w_done;
  logic              w_accept;   // start sampled in IDLE
  logic              w_cap_en;   // capture stage loads this edge

  logic [IN_W-1:0]   r_cnt;
  logic              w_last;

  logic              r_cap_vld;
  logic [OUT_W-1:0]  r_cap_exact;
  logic [OUT_W-1:0]  r_cap_approx;

  logic [IN_W:0]     r_err_count;
  logic [IN_W+3:0]   r_bit_err_sum;
  logic [OUT_W-1:0]  r_max_abs_err;

  logic [OUT_W-1:0]  w_xor;
  logic              w_ne;
  logic [IN_W+3:0]   w_pop;
  logic [OUT_W:0]    w_diff;
  logic [OUT_W-1:0]  w_abs_err;

  assign w_last = (r_cnt == CNT_LAST);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    w_cap_en    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_state_nxt = ST_SWEEP;
          w_accept    = 1'b1;
        end
      end
      ST_SWEEP: begin
        w_busy   = 1'b1;
        w_cap_en = 1'b1;
        if (w_last) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_busy      = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------- vector counter (drives pi directly) ----------------
  // Parks on the last vector instead of wrapping, so pi holds its final
  // value through DRAIN, DONE and IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_cap_en && !w_last) begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  // ---------------- capture stage ----------------
  // Loads the partition responses for the current pi on every SWEEP edge;
  // any other state (in particular DRAIN) empties it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cap_vld    <= 1'b0;
      r_cap_exact  <= '0;
      r_cap_approx <= '0;
    end else if (w_cap_en) begin
      r_cap_vld    <= 1'b1;
      r_cap_exact  <= bus.po_exact;
      r_cap_approx <= bus.po_approx;
    end else begin
      r_cap_vld    <= 1'b0;
    end
  end

  // ---------------- error metrics of the captured pair ----------------
  assign w_xor = r_cap_exact ^ r_cap_approx;
  assign w_ne  = |w_xor;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < OUT_W; i++) begin
      w_pop = w_pop + (IN_W+4)'(w_xor[i]);
    end
  end

  // Borrow bit of the OUT_W+1 subtraction tells which operand is larger;
  // a negative result is negated back to its magnitude.
  assign w_diff    = {1'b0, r_cap_exact} - {1'b0, r_cap_approx};
  assign w_abs_err = w_diff[OUT_W] ? (~w_diff[OUT_W-1:0] + OUT_ONE) : w_diff[OUT_W-1:0];

  // ---------------- accumulators ----------------
  // Widths cover the worst case (every vector wrong, every bit flipped), so
  // plain wrapping adders never actually wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count   <= '0;
      r_bit_err_sum <= '0;
      r_max_abs_err <= '0;
    end else if (w_accept) begin
      r_err_count   <= '0;
      r_bit_err_sum <= '0;
      r_max_abs_err <= '0;
    end else if (r_cap_vld) begin
      r_err_count   <= r_err_count + (IN_W+1)'(w_ne);
      r_bit_err_sum <= r_bit_err_sum + w_pop;
      if (w_abs_err > r_max_abs_err) begin
        r_max_abs_err <= w_abs_err;
      end
    end
  end

  assign bus.pi          = r_cnt;
  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.err_count   = r_err_count;
  assign bus.bit_err_sum = r_bit_err_sum;
  assign bus.max_abs_err = r_max_abs_err;

endmodule

// File: tb/tb_partition_err_sweep.sv
module tb_partition_err_sweep;
  localparam int IN_W  = 7;
  localparam int OUT_W = 4;
  localparam int NV    = 1 << IN_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  partition_err_sweep_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  partition_err_sweep #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int err;
    int bits;
    int mx;
  } res_t;

  int         checks   = 0;
  int         failures = 0;
  int         mode     = 0;
  logic [3:0] mask_lut [NV];
  res_t       exp_q [$];
  res_t       last_exp;

  // ---------------- partition models driven back into the DUT ----------------
  function automatic logic [3:0] exact_of(int v);
    return 4'(((v % 16) + (v / 16)) % 16);
  endfunction

  function automatic logic [3:0] approx_of(int v);
    logic [3:0] e;
    e = exact_of(v);
    case (mode)
      0:       return e;
      1:       return e & 4'hE;
      2:       return ~e;
      default: return e ^ mask_lut[v];
    endcase
  endfunction

  always_comb begin
    bus.po_exact  = exact_of(int'(bus.pi));
    bus.po_approx = approx_of(int'(bus.pi));
  end

  // Reference: whole-sweep statistics computed directly from the definitions.
  function automatic res_t model();
    res_t r;
    int   e, a, d;
    r.err = 0; r.bits = 0; r.mx = 0;
    for (int v = 0; v < NV; v++) begin
      e = int'(exact_of(v));
      a = int'(approx_of(v));
      if (e != a) r.err++;
      r.bits += $countones(4'(e ^ a));
      d = (e > a) ? e - a : a - e;
      if (d > r.mx) r.mx = d;
    end
    return r;
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- result monitor ----------------
  always @(negedge clk) begin : monitor
    res_t r;
    if (!rst && bus.done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        r = exp_q.pop_front();
        check("err_count",   int'(bus.err_count),   r.err);
        check("bit_err_sum", int'(bus.bit_err_sum), r.bits);
        check("max_abs_err", int'(bus.max_abs_err), r.mx);
      end
    end
  end

  // ---------------- one full sweep with timing / coverage checks ----------------
  task automatic run_sweep(int m, bit new_lut, int mid_pulse, bit done_pulse);
    int cyc, busy_cnt, pi_bad;
    bit got;
    mode = m;
    if (new_lut) begin
      for (int v = 0; v < NV; v++) begin
        mask_lut[v] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      end
    end
    last_exp = model();
    exp_q.push_back(last_exp);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 0; busy_cnt = 0; pi_bad = 0; got = 1'b0;
    while (cyc <= 400) begin
      if (bus.busy) busy_cnt++;
      if (cyc <= NV - 1 && int'(bus.pi) != cyc) pi_bad++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
      if (cyc == mid_pulse) bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      cyc++;
    end
    check("done_latency", got ? cyc : -1, NV + 1);
    check("busy_cycles", busy_cnt, NV + 1);
    check("pi_sequence_errors", pi_bad, 0);
    if (done_pulse) begin
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      check("start_in_done_ignored", int'(bus.busy), 0);
    end
    repeat (3) @(posedge clk);
    #1;
    check("hold_err_count",   int'(bus.err_count),   last_exp.err);
    check("hold_bit_err_sum", int'(bus.bit_err_sum), last_exp.bits);
    check("hold_max_abs_err", int'(bus.max_abs_err), last_exp.mx);
  endtask

  initial begin
    int   dones, idle_gap, cyc;
    bit   got;
    res_t r0, r1, r2;
    bus.start = 1'b0;

    // Reset state
    #3;
    check("rst_pi",   int'(bus.pi), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err",  int'(bus.err_count), 0);
    check("rst_bits", int'(bus.bit_err_sum), 0);
    check("rst_max",  int'(bus.max_abs_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Directed modes, then randomized approximate partitions
    run_sweep(0, 1'b0, -1, 1'b0);
    run_sweep(1, 1'b0, 60, 1'b1);
    run_sweep(2, 1'b0, -1, 1'b1);
    run_sweep(3, 1'b1, $urandom_range(1, 120), 1'b0);
    run_sweep(3, 1'b1, -1, 1'b0);

    // Abort mid-sweep with an asynchronous reset, then rerun the same sweep
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (int'(bus.pi) == 50) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("reached_pi_50", int'(got), 1);
    #1 rst = 1'b1;
    #1;
    check("abort_pi",   int'(bus.pi), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_err",  int'(bus.err_count), 0);
    check("abort_bits", int'(bus.bit_err_sum), 0);
    check("abort_max",  int'(bus.max_abs_err), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    run_sweep(3, 1'b0, -1, 1'b0);

    // start held high for 300 cycles
    mode = 1;
    r0 = model(); r1 = r0; r2 = r0;
    exp_q.push_back(r0);
    exp_q.push_back(r1);
    exp_q.push_back(r2);
    @(negedge clk);
    bus.start = 1'b1;
    dones = 0; idle_gap = 0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dones++;
      if (dones == 1 && !bus.busy && !bus.done) idle_gap++;
    end
    bus.start = 1'b0;
    check("held_start_done_pulses", dones, 2);
    check("held_start_idle_gap", idle_gap, 1);
    got = 1'b0;
    cyc = 0;
    while (cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.done) begin
        got = 1'b1;
        break;
      end
    end
    check("held_start_third_sweep_done", int'(got), 1);

    repeat (5) @(posedge clk);
    check("pending_results", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/partition_err_sweep.md
PARTITION_ERR_SWEEP -- requirements
Module: partition_err_sweep

Interface
REQ-001 Parameter IN_W, default 7, number of partition primary inputs; legal range 1..16.
REQ-002 Parameter OUT_W, default 4, number of partition primary outputs; legal range 1..8.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  sweep request; sampled only in IDLE.
REQ-006 pi  output  IN_W  input vector driven to the exact and approximate partitions.
REQ-007 po_exact  input  OUT_W  exact partition output; combinational response to pi.
REQ-008 po_approx  input  OUT_W  approximate partition output; combinational response to pi.
REQ-009 busy  output  1  high in SWEEP and DRAIN.
REQ-010 done  output  1  single-cycle pulse when results are final.
REQ-011 err_count  output  IN_W+1  number of vectors where po_exact != po_approx.
REQ-012 bit_err_sum  output  IN_W+4  total Hamming distance over all vectors.
REQ-013 max_abs_err  output  OUT_W  maximum unsigned |po_exact - po_approx| over all vectors.

Function
REQ-014 FSM states SHALL be IDLE, SWEEP, DRAIN and DONE.
REQ-015 IDLE: start=1 -> SWEEP; vector counter SHALL be 0; err_count, bit_err_sum and max_abs_err SHALL be cleared on the same edge.
REQ-016 SWEEP: pi SHALL equal the vector counter, ascending by 1 per cycle from 0 to 2^IN_W-1 with no gaps or repeats.
REQ-017 SWEEP: each edge SHALL register {po_exact, po_approx} for the current pi into a capture stage with valid=1.
REQ-018 Accumulation SHALL happen one edge after capture, from the capture stage only (one-cycle pipeline).
REQ-019 On each valid capture, err_count SHALL add 1 when the two values differ.
REQ-020 On each valid capture, bit_err_sum SHALL add popcount(exact XOR approx).
REQ-021 On each valid capture, max_abs_err SHALL update to max(current value, |exact-approx|), with the subtraction unsigned at OUT_W+1 bits.
REQ-022 SWEEP SHALL go to DRAIN on the edge that captures vector 2^IN_W-1; the counter SHALL NOT wrap past it.
REQ-023 DRAIN SHALL last exactly one cycle; it accumulates the final capture and clears valid; next state DONE.
REQ-024 DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-025 done SHALL first be high exactly 2^IN_W+1 cycles after the edge that sampled start.
REQ-026 Results SHALL hold stable from DONE until the next accepted start.
REQ-027 start while busy or in DONE SHALL be ignored; no restart and no effect on results.
REQ-028 In IDLE and DONE, pi SHALL hold its last driven value, and no accumulation SHALL occur.
REQ-029 Accumulators SHALL NOT saturate or overflow within legal parameter ranges, because their widths are sized for the worst case.

Reset
REQ-030 rst=1 SHALL immediately force IDLE and set pi, counter, capture valid, busy, done, err_count, bit_err_sum and max_abs_err to 0, independent of clk.
REQ-031 rst asserted mid-SWEEP or mid-DRAIN SHALL abandon the sweep; no done pulse SHALL follow. After release, a new start SHALL run a full sweep from pi=0.

Verification (IN_W=7, OUT_W=4; bench model exact = (pi[3:0]+pi[6:4]) mod 16)
REQ-032 approx = exact -> done 129 cycles after start; err_count=0, bit_err_sum=0, max_abs_err=0.
REQ-033 approx = exact with bit0 forced to 0 -> err_count=64, bit_err_sum=64, max_abs_err=1.
REQ-034 approx = ~exact -> err_count=128, bit_err_sum=512, max_abs_err=15.
REQ-035 During SWEEP, check that pi covers 0..127 in order, one value per cycle, and that busy is high for exactly 129 cycles.
REQ-036 rst pulse at pi=50, then start -> outputs read 0 at reset; no done from the aborted run; the fresh sweep gives the same results as an uninterrupted run.
REQ-037 start held high for 300 cycles -> exactly two sweeps and two done pulses, with IDLE (one cycle) between them; a start pulse mid-sweep -> no change in results or timing.
